reg_word_assembler: RTL and testbench

- Sits directly downstream of the bus interface stage and consumes its per-byte register strobes.
- Assembles even/odd byte writes into 16-bit register write transactions, queued in a small FIFO toward the register/VRAM arbiter (valid/ready).
- For reads, the even-byte read issues one 16-bit fetch request. The returned word is held so that the even and odd bytes can be presented on the bus.

---
 rtl/reg_word_assembler.sv | 200 ++++++++++++++++++++
 tb/tb_reg_word_assembler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_word_assembler.sv
// reg_word_assembler
//
// Turns the per-byte register strobes from the bus interface into 16-bit
// register transactions. Even (high) byte writes are latched; the odd (low)
// byte write completes the word and queues it in a small write FIFO toward
// the register/VRAM arbiter. An even byte read issues one 16-bit fetch. The
// returned word is held so that both bytes can be presented on the host bus.
//
// Parameters:
//   WR_FIFO_DEPTH  queued 16-bit writes (power of 2, 2..8)
//
// Ports:
//   clk, reset_i                      clock, synchronous active-high reset
//   write_strobe_i, read_strobe_i     one-cycle byte access pulses
//   reg_num_i, bytesel_i, bytedata_i  register, byte lane (1 = odd/low), data
//   wr_valid_o/wr_reg_o/wr_data_o     write FIFO head toward the arbiter
//   wr_ready_i                        arbiter pops the head
//   rd_req_o/rd_reg_o                 16-bit fetch request
//   rd_ack_i/rd_data_i                fetch completion and returned word
//   bus_data_o                        byte driven onto the host data bus
//   overrun_o/overrun_clr_i           sticky error flag and its clear
//
// Build option:
//   REG_HI_LATCH_PER_REG_EN  when defined, each of the 16 registers has its
//                            own high-byte latch instead of one shared latch.

module reg_word_assembler #(
    parameter int WR_FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        write_strobe_i,
    input  logic        read_strobe_i,
    input  logic [3:0]  reg_num_i,
    input  logic        bytesel_i,
    input  logic [7:0]  bytedata_i,
    output logic        wr_valid_o,
    output logic [3:0]  wr_reg_o,
    output logic [15:0] wr_data_o,
    input  logic        wr_ready_i,
    output logic        rd_req_o,
    output logic [3:0]  rd_reg_o,
    input  logic        rd_ack_i,
    input  logic [15:0] rd_data_i,
    output logic [7:0]  bus_data_o,
    output logic        overrun_o,
    input  logic        overrun_clr_i
);

    localparam int PTR_W = (WR_FIFO_DEPTH > 1) ? $clog2(WR_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(WR_FIFO_DEPTH) + 1;

    typedef enum logic {
        RD_IDLE,
        RD_REQ
    } rd_state_t;

    rd_state_t        state, next_state;

    logic [3:0]       fifo_reg  [WR_FIFO_DEPTH];
    logic [15:0]      fifo_data [WR_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic             push_req, push, pop, full, drop;
    logic             even_wr, even_rd, rd_issue;
    logic [7:0]       hi_sel;
    logic [15:0]      rd_word;
    logic             last_sel;

    assign even_wr  = write_strobe_i & ~bytesel_i;
    assign even_rd  = read_strobe_i & ~bytesel_i;
    assign push_req = write_strobe_i & bytesel_i;
    assign full     = (count == CNT_W'(WR_FIFO_DEPTH));
    assign pop      = wr_valid_o & wr_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

`ifdef REG_HI_LATCH_PER_REG_EN
    logic [7:0] hi_latch [16];

    assign hi_sel = hi_latch[reg_num_i];

    // Per-register high-byte latches, loaded by even byte writes.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            for (int i = 0; i < 16; i++) hi_latch[i] <= 8'h00;
        end else if (even_wr) begin
            hi_latch[reg_num_i] <= bytedata_i;
        end
    end
`else
    logic [7:0] hi_latch;

    assign hi_sel = hi_latch;

    // Shared high-byte latch; kept after an odd write so it can be reused.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            hi_latch <= 8'h00;
        end else if (even_wr) begin
            hi_latch <= bytedata_i;
        end
    end
`endif

    // Write FIFO. Storage is cleared on reset so the head outputs read 0.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < WR_FIFO_DEPTH; i++) begin
                fifo_reg[i]  <= 4'h0;
                fifo_data[i] <= 16'h0000;
            end
        end else begin
            if (push) begin
                fifo_reg[wr_ptr]  <= reg_num_i;
                fifo_data[wr_ptr] <= {hi_sel, bytedata_i};
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign wr_valid_o = (count != '0);
    assign wr_reg_o   = fifo_reg[rd_ptr];
    assign wr_data_o  = fifo_data[rd_ptr];

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state <= RD_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The request is held back while writes are queued or being pushed so
    // that a read always observes every earlier write. An ack only counts
    // once the request is actually visible to the arbiter.
    always_comb begin
        next_state = state;
        rd_issue   = 1'b0;
        case (state)
            RD_IDLE: begin
                if (even_rd) next_state = RD_REQ;
            end
            RD_REQ: begin
                rd_issue = (count == '0) & ~push;
                if (rd_issue && rd_ack_i) next_state = RD_IDLE;
            end
            default: next_state = RD_IDLE;
        endcase
    end

    assign rd_req_o = rd_issue;

    // Read register capture, returned word, and the host bus byte.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            rd_reg_o   <= 4'h0;
            rd_word    <= 16'h0000;
            last_sel   <= 1'b0;
            bus_data_o <= 8'h00;
        end else begin
            if (state == RD_IDLE && even_rd) begin
                rd_reg_o <= reg_num_i;
            end
            if (rd_issue && rd_ack_i) begin
                rd_word <= rd_data_i;
            end
            if (read_strobe_i) begin
                last_sel <= bytesel_i;
            end
            bus_data_o <= last_sel ? rd_word[7:0] : rd_word[15:8];
        end
    end

    // Sticky overrun: a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            overrun_o <= 1'b0;
        end else if (drop || (even_rd && state == RD_REQ)) begin
            overrun_o <= 1'b1;
        end else if (overrun_clr_i) begin
            overrun_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_word_assembler.sv
// Testbench for reg_word_assembler: directed scenarios followed by random
// traffic, checked against a transaction-level reference model and a
// write scoreboard.
module tb_reg_word_assembler;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        write_strobe_i = 1'b0;
    logic        read_strobe_i = 1'b0;
    logic [3:0]  reg_num_i = 4'h0;
    logic        bytesel_i = 1'b0;
    logic [7:0]  bytedata_i = 8'h00;
    logic        wr_valid_o;
    logic [3:0]  wr_reg_o;
    logic [15:0] wr_data_o;
    logic        wr_ready_i = 1'b0;
    logic        rd_req_o;
    logic [3:0]  rd_reg_o;
    logic        rd_ack_i = 1'b0;
    logic [15:0] rd_data_i = 16'h0000;
    logic [7:0]  bus_data_o;
    logic        overrun_o;
    logic        overrun_clr_i = 1'b0;

    always #5 clk = ~clk;

    reg_word_assembler #(.WR_FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .write_strobe_i (write_strobe_i),
        .read_strobe_i  (read_strobe_i),
        .reg_num_i      (reg_num_i),
        .bytesel_i      (bytesel_i),
        .bytedata_i     (bytedata_i),
        .wr_valid_o     (wr_valid_o),
        .wr_reg_o       (wr_reg_o),
        .wr_data_o      (wr_data_o),
        .wr_ready_i     (wr_ready_i),
        .rd_req_o       (rd_req_o),
        .rd_reg_o       (rd_reg_o),
        .rd_ack_i       (rd_ack_i),
        .rd_data_i      (rd_data_i),
        .bus_data_o     (bus_data_o),
        .overrun_o      (overrun_o),
        .overrun_clr_i  (overrun_clr_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is an occupancy count plus a queue of the
    // words it should deliver; the read side is a pending flag and a word.
    typedef struct packed {
        logic [3:0]  r;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          m_cnt = 0;
    bit          m_pend = 0;
    logic [3:0]  m_rreg = 4'h0;
    logic [15:0] m_word = 16'h0000;
    bit          m_lsel = 0;
    logic [7:0]  m_bus = 8'h00;
    bit          m_ovr = 0;
    logic [7:0]  m_hi [16];
    bit          model_en = 0;

    initial for (int i = 0; i < 16; i++) m_hi[i] = 8'h00;

    // Inputs change 2 time units after posedge, so at negedge the model sees
    // the current state together with the inputs of the coming edge.
    always @(negedge clk) begin
        bit    push_req, pop, exp_req, set_ovr, new_pend, ack_ok;
        int    hidx;
        wr_t   e;
        if (model_en) begin
            push_req = write_strobe_i && bytesel_i;
            exp_req  = m_pend && (m_cnt == 0) && !push_req;
            checkOutput("wr_valid", {31'd0, wr_valid_o}, {31'd0, m_cnt > 0});
            checkOutput("rd_req", {31'd0, rd_req_o}, {31'd0, exp_req});
            if (m_pend) checkOutput("rd_reg", {28'd0, rd_reg_o}, {28'd0, m_rreg});
            checkOutput("bus_data", {24'd0, bus_data_o}, {24'd0, m_bus});
            checkOutput("overrun", {31'd0, overrun_o}, {31'd0, m_ovr});
            if (reset_i) begin
                exp_q.delete();
                m_cnt = 0; m_pend = 0; m_rreg = 4'h0; m_word = 16'h0000;
                m_lsel = 0; m_bus = 8'h00; m_ovr = 0;
                for (int i = 0; i < 16; i++) m_hi[i] = 8'h00;
            end else begin
`ifdef REG_HI_LATCH_PER_REG_EN
                hidx = int'(reg_num_i);
`else
                hidx = 0;
`endif
                set_ovr = 0;
                pop = wr_ready_i && (m_cnt > 0);
                if (push_req) begin
                    if (m_cnt < DEPTH || pop) begin
                        e.r = reg_num_i;
                        e.d = {m_hi[hidx], bytedata_i};
                        exp_q.push_back(e);
                        m_cnt++;
                    end else begin
                        set_ovr = 1;
                    end
                end
                if (pop) m_cnt--;
                if (write_strobe_i && !bytesel_i) m_hi[hidx] = bytedata_i;
                m_bus = m_lsel ? m_word[7:0] : m_word[15:8];
                ack_ok = exp_req && rd_ack_i;
                if (ack_ok) m_word = rd_data_i;
                new_pend = m_pend && !ack_ok;
                if (read_strobe_i) begin
                    m_lsel = bytesel_i;
                    if (!bytesel_i) begin
                        if (m_pend) set_ovr = 1;
                        else begin
                            new_pend = 1;
                            m_rreg = reg_num_i;
                        end
                    end
                end
                m_pend = new_pend;
                m_ovr = set_ovr ? 1'b1 : (overrun_clr_i ? 1'b0 : m_ovr);
            end
        end
    end

    // Scoreboard monitor: every accepted FIFO head must match the oldest
    // expected write.
    always @(negedge clk) begin
        wr_t e;
        #1;
        if (model_en && !reset_i && wr_valid_o && wr_ready_i) begin
            if (exp_q.size() == 0) begin
                checkOutput("wr_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("wr_reg", {28'd0, wr_reg_o}, {28'd0, e.r});
                checkOutput("wr_data", {16'd0, wr_data_o}, {16'd0, e.d});
            end
        end
    end

    // Arbiter emulation for the read side.
    bit          arb_directed = 0;
    int          arb_target = 3;
    logic [15:0] arb_data = 16'h0000;
    bit          arb_idle_ack = 0;
    int          req_run = 0;

    always @(posedge clk) begin
        #3;
        if (rd_req_o) req_run++;
        else req_run = 0;
        if (arb_idle_ack) begin
            rd_ack_i  = 1'b1;
            rd_data_i = 16'($urandom);
        end else if (rd_req_o && (arb_directed ? (req_run >= arb_target) : ($urandom_range(0, 2) == 0))) begin
            rd_ack_i  = 1'b1;
            rd_data_i = arb_directed ? arb_data : 16'($urandom);
        end else begin
            rd_ack_i  = 1'b0;
            rd_data_i = 16'($urandom);
        end
    end

    task automatic applyStimulus(input bit rst, input bit ws, input bit rs, input logic [3:0] r,
                                 input bit sel, input logic [7:0] d, input bit rdy, input bit clr);
        @(posedge clk);
        #2;
        reset_i        = rst;
        write_strobe_i = ws;
        read_strobe_i  = rs;
        reg_num_i      = r;
        bytesel_i      = sel;
        bytedata_i     = d;
        wr_ready_i     = rdy;
        overrun_clr_i  = clr;
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 4'h0, 0, 8'h00, rdy, 0);
    endtask

    initial begin
        @(posedge clk);
        #2;
        model_en = 1;
        applyStimulus(1, 0, 0, 4'h0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 4'h0, 0, 8'h00, 0, 0);
        checkOutput("rst_wr_valid", {31'd0, wr_valid_o}, 32'd0);
        checkOutput("rst_wr_reg", {28'd0, wr_reg_o}, 32'd0);
        checkOutput("rst_wr_data", {16'd0, wr_data_o}, 32'd0);
        checkOutput("rst_rd_reg", {28'd0, rd_reg_o}, 32'd0);
        checkOutput("rst_bus", {24'd0, bus_data_o}, 32'd0);
        checkOutput("rst_overrun", {31'd0, overrun_o}, 32'd0);

        $display("[TB] basic word assembly");
        applyStimulus(0, 1, 0, 4'd3, 0, 8'hAB, 1, 0);
        applyStimulus(0, 1, 0, 4'd3, 1, 8'hCD, 1, 0);
        idle(1, 1);
        checkOutput("t1_valid", {31'd0, wr_valid_o}, 32'd1);
        checkOutput("t1_reg", {28'd0, wr_reg_o}, 32'd3);
        checkOutput("t1_data", {16'd0, wr_data_o}, 32'h0000ABCD);
        idle(1, 1);
        checkOutput("t1_single_pulse", {31'd0, wr_valid_o}, 32'd0);

        $display("[TB] fifo full and overrun");
        applyStimulus(0, 1, 0, 4'd1, 0, 8'h00, 0, 0);
        applyStimulus(0, 1, 0, 4'd1, 1, 8'h11, 0, 0);
        applyStimulus(0, 1, 0, 4'd2, 1, 8'h22, 0, 0);
        applyStimulus(0, 1, 0, 4'd4, 1, 8'h44, 0, 0);
        idle(0, 2);
        checkOutput("t2_overrun", {31'd0, overrun_o}, 32'd1);
        checkOutput("t2_head", {16'd0, wr_data_o}, 32'h00000011);
        idle(1, 3);
        checkOutput("t2_drained", {31'd0, wr_valid_o}, 32'd0);
        applyStimulus(0, 0, 0, 4'h0, 0, 8'h00, 1, 1);
        idle(1, 1);
        checkOutput("t2_cleared", {31'd0, overrun_o}, 32'd0);

        $display("[TB] read with delayed ack");
        arb_directed = 1; arb_target = 3; arb_data = 16'h1234;
        applyStimulus(0, 0, 1, 4'd5, 0, 8'h00, 1, 0);
        idle(1, 8);
        checkOutput("t3_bus_hi", {24'd0, bus_data_o}, 32'h12);
        applyStimulus(0, 0, 1, 4'd5, 1, 8'h00, 1, 0);
        idle(1, 2);
        checkOutput("t3_bus_lo", {24'd0, bus_data_o}, 32'h34);
        checkOutput("t3_no_req", {31'd0, rd_req_o}, 32'd0);

        $display("[TB] read waits for queued write");
        arb_target = 2; arb_data = 16'hBEEF;
        applyStimulus(0, 1, 0, 4'd7, 1, 8'h77, 0, 0);
        applyStimulus(0, 0, 1, 4'd7, 0, 8'h00, 0, 0);
        idle(0, 4);
        checkOutput("t4_req_blocked", {31'd0, rd_req_o}, 32'd0);
        idle(1, 8);

        $display("[TB] second read during request");
        arb_target = 4; arb_data = 16'h5A5A;
        applyStimulus(0, 0, 1, 4'd9, 0, 8'h00, 1, 0);
        applyStimulus(0, 0, 1, 4'd10, 0, 8'h00, 1, 0);
        idle(1, 8);
        checkOutput("t5_overrun", {31'd0, overrun_o}, 32'd1);
        checkOutput("t5_rd_reg", {28'd0, rd_reg_o}, 32'd9);
        applyStimulus(0, 0, 0, 4'h0, 0, 8'h00, 1, 1);

        $display("[TB] ack while idle");
        arb_idle_ack = 1;
        idle(1, 3);
        arb_idle_ack = 0;
        idle(1, 2);

        $display("[TB] high latch selection");
        applyStimulus(0, 1, 0, 4'd0, 0, 8'h11, 0, 0);
        applyStimulus(0, 1, 0, 4'd1, 0, 8'h22, 0, 0);
        applyStimulus(0, 1, 0, 4'd0, 1, 8'h33, 0, 0);
        idle(0, 1);
`ifdef REG_HI_LATCH_PER_REG_EN
        checkOutput("t6_data", {16'd0, wr_data_o}, 32'h00001133);
`else
        checkOutput("t6_data", {16'd0, wr_data_o}, 32'h00002233);
`endif
        idle(1, 2);

        $display("[TB] random traffic");
        arb_directed = 0;
        for (int k = 0; k < 3000; k++) begin
            int  r;
            bit  rst;
            r   = $urandom_range(0, 99);
            rst = ($urandom_range(0, 499) == 0);
            applyStimulus(rst, r < 30, (r >= 30) && (r < 45), 4'($urandom), 1'($urandom),
                          8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 30) == 0);
        end

        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0 && !m_pend) break;
            idle(1, 1);
        end
        idle(1, 2);
        checkOutput("drain_fifo", exp_q.size(), 32'd0);
        checkOutput("drain_read", {31'd0, m_pend}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
